// File: rtl/traffic_ctrl_param.sv
// traffic_ctrl_param
//   Parameterised multi-phase traffic-light controller. Phases cycle
//   GREEN -> YELLOW -> ALLRED, skipping phases masked off in phase_en.
//   An emergency request parks the intersection in all-red and later
//   resumes exactly where it left off. A maintenance request flashes
//   all yellow lamps.
//
// Ports
//   clk          : rising-edge clock
//   rst          : asynchronous active-high reset
//   ec           : emergency request (highest priority)
//   flash        : flashing-yellow maintenance request
//   phase_en     : per-phase enable mask, sampled only when ALLRED expires
//   light        : registered lamps, phase i -> {red, yellow, green} at [3i+2:3i]
//   phase_idx    : registered index of the current phase
//   emerg_active : registered, high while in EMERG
module traffic_ctrl_param #(
  parameter int NUM_PHASES  = 4,
  parameter int CNT_W       = 6,
  parameter int GREEN_TIME  = 20,
  parameter int YELLOW_TIME = 4,
  parameter int ALLRED_TIME = 2,
  parameter int FLASH_TIME  = 8,
  localparam int IDX_W      = $clog2(NUM_PHASES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ec,
  input  logic                    flash,
  input  logic [NUM_PHASES-1:0]   phase_en,
  output logic [3*NUM_PHASES-1:0] light,
  output logic [IDX_W-1:0]        phase_idx,
  output logic                    emerg_active
);

  typedef enum logic [2:0] {
    ST_GREEN,
    ST_YELLOW,
    ST_ALLRED,
    ST_EMERG,
    ST_FLASH
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TIME - 1);
  localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_TIME - 1);
  localparam logic [IDX_W-1:0] LAST_PH   = IDX_W'(NUM_PHASES - 1);
  localparam logic [3*NUM_PHASES-1:0] ALL_RED = {NUM_PHASES{3'b100}};

  state_t           state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [IDX_W-1:0] phase_n;
  logic             flash_tog, tog_n;

  // Context parked while EMERG is active
  state_t           sv_state, sv_state_n;
  logic [CNT_W-1:0] sv_timer, sv_timer_n;
  logic [IDX_W-1:0] sv_phase, sv_phase_n;

  logic             nxt_found;
  logic [IDX_W-1:0] nxt_phase;

  // First enabled phase searching upward from cur+1, wrapping; the current
  // phase is the last candidate. MSB of the result flags that one was found.
  function automatic logic [IDX_W:0] find_next(input logic [IDX_W-1:0] cur,
                                               input logic [NUM_PHASES-1:0] en);
    logic [IDX_W:0] res;
    int             p;
    res = {1'b0, cur};
    // Descending scan so the nearest candidate is the one that sticks
    for (int k = NUM_PHASES; k >= 1; k--) begin
      p = (int'(cur) + k) % NUM_PHASES;
      if (en[p]) res = {1'b1, IDX_W'(p)};
    end
    return res;
  endfunction

  // Lamp pattern for a given state/phase/flash-toggle combination
  function automatic logic [3*NUM_PHASES-1:0] lamps(input state_t st,
                                                    input logic [IDX_W-1:0] ph,
                                                    input logic tog);
    logic [3*NUM_PHASES-1:0] l;
    l = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      case (st)
        ST_GREEN: begin
          if (IDX_W'(i) == ph) l[3*i] = 1'b1;
          else                 l[3*i+2] = 1'b1;
        end
        ST_YELLOW: begin
          if (IDX_W'(i) == ph) l[3*i+1] = 1'b1;
          else                 l[3*i+2] = 1'b1;
        end
        // Yellow lamps are lit while the toggle is clear, so entry shows them on
        ST_FLASH: l[3*i+1] = ~tog;
        default:  l[3*i+2] = 1'b1;
      endcase
    end
    return l;
  endfunction

  assign {nxt_found, nxt_phase} = find_next(phase_idx, phase_en);

  // Next-state decision
  always_comb begin
    state_n    = state;
    timer_n    = timer;
    phase_n    = phase_idx;
    tog_n      = flash_tog;
    sv_state_n = sv_state;
    sv_timer_n = sv_timer;
    sv_phase_n = sv_phase;

    if (ec && state != ST_EMERG) begin
      state_n    = ST_EMERG;
      sv_phase_n = phase_idx;
      // Leaving FLASH for an emergency returns through a fresh clearance
      if (state == ST_FLASH) begin
        sv_state_n = ST_ALLRED;
        sv_timer_n = ALLRED_LD;
      end else begin
        sv_state_n = state;
        sv_timer_n = timer;
      end
    end else begin
      case (state)
        ST_EMERG: begin
          if (!ec) begin
            state_n = sv_state;
            timer_n = sv_timer;
            phase_n = sv_phase;
          end
        end
        ST_FLASH: begin
          if (!flash) begin
            state_n = ST_ALLRED;
            timer_n = ALLRED_LD;
          end else if (timer == '0) begin
            tog_n   = ~flash_tog;
            timer_n = FLASH_LD;
          end else begin
            timer_n = timer - CNT_W'(1);
          end
        end
        default: begin
          if (flash) begin
            state_n = ST_FLASH;
            timer_n = FLASH_LD;
            tog_n   = 1'b0;
          end else if (timer != '0) begin
            timer_n = timer - CNT_W'(1);
          end else begin
            case (state)
              ST_GREEN: begin
                state_n = ST_YELLOW;
                timer_n = YELLOW_LD;
              end
              ST_YELLOW: begin
                state_n = ST_ALLRED;
                timer_n = ALLRED_LD;
              end
              default: begin
                // With no enabled phase the clearance simply repeats
                timer_n = ALLRED_LD;
                if (nxt_found) begin
                  state_n = ST_GREEN;
                  timer_n = GREEN_LD;
                  phase_n = nxt_phase;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  // State and registered outputs share one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_ALLRED;
      timer        <= ALLRED_LD;
      phase_idx    <= LAST_PH;
      flash_tog    <= 1'b0;
      sv_state     <= ST_ALLRED;
      sv_timer     <= ALLRED_LD;
      sv_phase     <= LAST_PH;
      light        <= ALL_RED;
      emerg_active <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      phase_idx    <= phase_n;
      flash_tog    <= tog_n;
      sv_state     <= sv_state_n;
      sv_timer     <= sv_timer_n;
      sv_phase     <= sv_phase_n;
      light        <= lamps(state_n, phase_n, tog_n);
      emerg_active <= (state_n == ST_EMERG);
    end
  end

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Bench for traffic_ctrl_param: a cycle-level model of the controller's
// rules (interval lengths in cycles, saved context, flash cycle count)
// is advanced on every rising edge and compared on every falling edge.
// Directed scenarios pin the model with hand-counted expectations,
// followed by a randomized run.
module tb_traffic_ctrl_param;

  localparam int NP = 4;
  localparam int CW = 6;
  localparam int GT = 20;
  localparam int YT = 4;
  localparam int AT = 2;
  localparam int FT = 8;
  localparam int LW = 3 * NP;

  localparam logic [LW-1:0] ALL_RED = {NP{3'b100}};
  localparam logic [LW-1:0] ALL_Y   = {NP{3'b010}};
  localparam logic [LW-1:0] ALL_OFF = '0;

  localparam int MG = 0, MY = 1, MA = 2, ME = 3, MF = 4;

  logic          clk, rst, ec, flash;
  logic [NP-1:0] phase_en;
  logic [LW-1:0] light;
  logic [1:0]    phase_idx;
  logic          emerg_active;

  int total, bad;
  bit chk_en;

  // Model: mode, cycles left in the current interval (counting the present
  // one), phase, parked context, and cycles spent so far in FLASH.
  int m_mode, m_rem, m_phase;
  int s_mode, s_rem, s_phase;
  int m_fcnt;

  traffic_ctrl_param #(
    .NUM_PHASES(NP), .CNT_W(CW), .GREEN_TIME(GT), .YELLOW_TIME(YT),
    .ALLRED_TIME(AT), .FLASH_TIME(FT)
  ) dut (
    .clk(clk), .rst(rst), .ec(ec), .flash(flash), .phase_en(phase_en),
    .light(light), .phase_idx(phase_idx), .emerg_active(emerg_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] gpat(input int p);
    logic [LW-1:0] l;
    l = ALL_RED;
    l[3*p+2] = 1'b0;
    l[3*p]   = 1'b1;
    return l;
  endfunction

  function automatic logic [LW-1:0] ypat(input int p);
    logic [LW-1:0] l;
    l = ALL_RED;
    l[3*p+2] = 1'b0;
    l[3*p+1] = 1'b1;
    return l;
  endfunction

  function automatic logic [LW-1:0] exp_light();
    case (m_mode)
      MG: return gpat(m_phase);
      MY: return ypat(m_phase);
      MF: return ((m_fcnt / FT) % 2 == 0) ? ALL_Y : ALL_OFF;
      default: return ALL_RED;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = MA; m_rem = AT; m_phase = NP - 1;
    s_mode = MA; s_rem = AT; s_phase = NP - 1;
    m_fcnt = 0;
  endtask

  task automatic model_step();
    bit found;
    int p;
    if (rst) begin
      model_reset();
    end else if (ec && m_mode != ME) begin
      if (m_mode == MF) begin s_mode = MA; s_rem = AT; end
      else begin s_mode = m_mode; s_rem = m_rem; end
      s_phase = m_phase;
      m_mode  = ME;
    end else if (m_mode == ME) begin
      if (!ec) begin m_mode = s_mode; m_rem = s_rem; m_phase = s_phase; end
    end else if (m_mode == MF) begin
      if (!flash) begin m_mode = MA; m_rem = AT; end
      else m_fcnt++;
    end else if (flash) begin
      m_mode = MF; m_fcnt = 0;
    end else if (m_rem > 1) begin
      m_rem--;
    end else if (m_mode == MG) begin
      m_mode = MY; m_rem = YT;
    end else if (m_mode == MY) begin
      m_mode = MA; m_rem = AT;
    end else begin
      found = 1'b0;
      for (int k = 1; k <= NP; k++) begin
        p = (m_phase + k) % NP;
        if (!found && phase_en[p]) begin found = 1'b1; m_phase = p; end
      end
      m_rem = found ? GT : AT;
      if (found) m_mode = MG;
    end
  endtask

  // Advance one clock; inputs change 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic set_rst(input logic v);
    rst = v;
    if (v) model_reset();
  endtask

  task automatic count_run(input logic [LW-1:0] pat, output int n);
    n = 0;
    while (light === pat && n < 1000) begin
      n++;
      tick();
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("light", 32'(light), 32'(exp_light()));
      chk("phase_idx", 32'(phase_idx), 32'(m_phase));
      chk("emerg_active", 32'(emerg_active), 32'(m_mode == ME));
    end
  end

  initial begin
    int n, viol, saw2;
    total = 0; bad = 0; chk_en = 1'b0;
    rst = 1'b0; ec = 1'b0; flash = 1'b0; phase_en = 4'b1111;
    model_reset();
    #1 set_rst(1'b1);
    chk_en = 1'b1;
    #1;
    chk("rst_light", 32'(light), 32'h924);
    chk("rst_idx", 32'(phase_idx), 32'd3);
    chk("rst_emerg", 32'(emerg_active), 32'd0);
    repeat (3) tick();
    set_rst(1'b0);

    // Boot sequence and phase rotation with all phases enabled
    count_run(ALL_RED, n);   chk("boot_allred_len", 32'(n), 32'd2);
    chk("first_green", 32'(light), 32'h921);
    count_run(gpat(0), n);   chk("g0_len", 32'(n), 32'd20);
    count_run(ypat(0), n);   chk("y0_len", 32'(n), 32'd4);
    count_run(ALL_RED, n);   chk("ar0_len", 32'(n), 32'd2);
    for (int p = 1; p <= 4; p++) begin
      chk("seq_idx", 32'(phase_idx), 32'(p % NP));
      chk("seq_green", 32'(light), 32'(gpat(p % NP)));
      repeat (GT + YT + AT) tick();
    end

    // Emergency during green cycle 7 of phase 0, held for 10 cycles
    set_rst(1'b1); tick(); tick(); set_rst(1'b0);
    count_run(ALL_RED, n);
    repeat (7) tick();
    ec = 1'b1;
    n = 0;
    repeat (10) begin
      tick();
      if (light === ALL_RED && emerg_active === 1'b1) n++;
    end
    chk("emerg_len", 32'(n), 32'd10);
    ec = 1'b0;
    tick();
    chk("emerg_drop", 32'(emerg_active), 32'd0);
    count_run(gpat(0), n);   chk("g0_resume_len", 32'(n), 32'd13);

    // Flash requested during yellow
    flash = 1'b1;
    tick();
    count_run(ALL_Y, n);     chk("flash_on_len", 32'(n), 32'd8);
    count_run(ALL_OFF, n);   chk("flash_off_len", 32'(n), 32'd8);
    flash = 1'b0;
    tick();
    count_run(ALL_RED, n);   chk("post_flash_ar", 32'(n), 32'd2);
    chk("post_flash_idx", 32'(phase_idx), 32'd1);

    // Empty mask parks in all-red; enabling phase 3 resumes there
    phase_en = 4'b0000;
    repeat (60) tick();
    chk("empty_mask_red", 32'(light), 32'(ALL_RED));
    phase_en = 4'b1000;
    count_run(ALL_RED, n);
    chk("mask8_wait", 32'(n <= 2), 32'd1);
    chk("mask8_idx", 32'(phase_idx), 32'd3);
    chk("mask8_green", 32'(light), 32'(gpat(3)));

    // Reset while in EMERG
    ec = 1'b1;
    repeat (3) tick();
    set_rst(1'b1);
    #1;
    chk("rst_emerg_light", 32'(light), 32'(ALL_RED));
    chk("rst_emerg_flag", 32'(emerg_active), 32'd0);
    ec = 1'b0; phase_en = 4'b1111;
    tick();
    set_rst(1'b0);
    count_run(ALL_RED, n);
    chk("rst_emerg_first", 32'(phase_idx), 32'd0);

    // Alternating phases 0 and 2
    set_rst(1'b1); phase_en = 4'b0101; tick(); set_rst(1'b0);
    count_run(ALL_RED, n);
    viol = 0; saw2 = 0;
    repeat (150) begin
      tick();
      if (phase_idx[0] !== 1'b0) viol++;
      if (light === gpat(2)) saw2 = 1;
    end
    chk("mask5_no_odd", 32'(viol), 32'd0);
    chk("mask5_saw2", 32'(saw2), 32'd1);

    // Randomized run
    for (int c = 0; c < 4000; c++) begin
      if (ec) begin if ($urandom_range(0, 9) == 0) ec = 1'b0; end
      else if ($urandom_range(0, 79) == 0) ec = 1'b1;
      if (flash) begin if ($urandom_range(0, 24) == 0) flash = 1'b0; end
      else if ($urandom_range(0, 99) == 0) flash = 1'b1;
      if ($urandom_range(0, 29) == 0)
        phase_en = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      if (rst) set_rst(1'b0);
      else if ($urandom_range(0, 599) == 0) set_rst(1'b1);
      tick();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
